// File: rtl/sddr_cpu_line_bridge.sv
// CPU word-access to DDR line bridge: one tagged line buffer, local read hits,
// write-through with read-modify-write fill on a miss.
module sddr_cpu_line_bridge #(
  parameter int unsigned BANK_BITS    = 3,
  parameter int unsigned ROW_BITS     = 13,
  parameter int unsigned COL_BITS     = 10,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned BURST_LENGTH = 8,
  localparam int unsigned ADDR_BITS   = BANK_BITS + ROW_BITS + COL_BITS + $clog2(DATA_BITS / 8),
  localparam int unsigned LINE_BITS   = BURST_LENGTH * DATA_BITS,
  localparam int unsigned OFS_BITS    = $clog2(LINE_BITS / 8)
) (
  input  logic                 cpu_clock_i,
  input  logic                 reset_i,
  input  logic                 cpu_cmd_valid,
  output logic                 cpu_cmd_ready,
  input  logic [31:0]          cpu_cmd_address,
  input  logic                 cpu_cmd_write,
  input  logic [3:0]           cpu_cmd_be,
  input  logic [31:0]          cpu_cmd_data,
  output logic                 cpu_rsp_valid,
  output logic [31:0]          cpu_rsp_data,
  output logic                 data_cmd_valid,
  output logic [ADDR_BITS-1:0] data_cmd_address,
  output logic                 data_cmd_write,
  output logic [LINE_BITS-1:0] data_cmd_data_o,
  input  logic                 data_cmd_ack,
  input  logic                 data_rsp_ready,
  input  logic [LINE_BITS-1:0] data_rsp_data_i
);

  localparam int unsigned TAG_BITS  = ADDR_BITS - OFS_BITS;
  localparam int unsigned WIDX_BITS = OFS_BITS - 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_FILL_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL_WAIT = 2'd2;
  localparam logic [1:0] ST_WB_REQ    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 line_valid_q, line_valid_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 req_write_q, req_write_d;
  logic [WIDX_BITS-1:0] req_widx_q, req_widx_d;
  logic [3:0]           req_be_q, req_be_d;
  logic [31:0]          req_data_q, req_data_d;
  logic [TAG_BITS-1:0]  req_tag_q, req_tag_d;
  logic                 rsp_prev_q;

  logic                 cpu_cmd_ready_d;
  logic                 cpu_rsp_valid_d;
  logic [31:0]          cpu_rsp_data_d;
  logic                 data_cmd_valid_d;
  logic [ADDR_BITS-1:0] data_cmd_address_d;
  logic                 data_cmd_write_d;
  logic [LINE_BITS-1:0] data_cmd_data_d;

  logic [TAG_BITS-1:0]  in_tag_c;
  logic [WIDX_BITS-1:0] in_widx_c;
  logic                 cmd_fire_c;
  logic                 ack_fire_c;
  logic                 rsp_edge_c;
  logic                 hit_c;
  logic [LINE_BITS-1:0] merged_c;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_cmd_address[31:ADDR_BITS], cpu_cmd_address[1:0]};

  // Replace the enabled bytes of word widx within a line
  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0] line,
    input logic [WIDX_BITS-1:0] widx,
    input logic [3:0]           be,
    input logic [31:0]          data
  );
    logic [LINE_BITS-1:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[32*int'(widx) + 8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] pick_word(
    input logic [LINE_BITS-1:0] line,
    input logic [WIDX_BITS-1:0] widx
  );
    return line[32*int'(widx) +: 32];
  endfunction

  assign in_tag_c   = cpu_cmd_address[ADDR_BITS-1:OFS_BITS];
  assign in_widx_c  = cpu_cmd_address[OFS_BITS-1:2];
  assign cmd_fire_c = cpu_cmd_valid && cpu_cmd_ready;
  assign ack_fire_c = data_cmd_valid && data_cmd_ack;
  assign rsp_edge_c = data_rsp_ready && !rsp_prev_q;
  assign hit_c      = line_valid_q && (tag_q == in_tag_c);

  // Next-state and next-output logic
  always_comb begin
    state_d            = state_q;
    line_valid_d       = line_valid_q;
    tag_d              = tag_q;
    line_d             = line_q;
    req_write_d        = req_write_q;
    req_widx_d         = req_widx_q;
    req_be_d           = req_be_q;
    req_data_d         = req_data_q;
    req_tag_d          = req_tag_q;
    cpu_cmd_ready_d    = cpu_cmd_ready;
    cpu_rsp_valid_d    = 1'b0;
    cpu_rsp_data_d     = cpu_rsp_data;
    data_cmd_valid_d   = data_cmd_valid;
    data_cmd_address_d = data_cmd_address;
    data_cmd_write_d   = data_cmd_write;
    data_cmd_data_d    = data_cmd_data_o;
    merged_c           = '0;

    case (state_q)
      ST_IDLE: begin
        cpu_cmd_ready_d = 1'b1;
        if (cmd_fire_c) begin
          req_write_d = cpu_cmd_write;
          req_widx_d  = in_widx_c;
          req_be_d    = cpu_cmd_be;
          req_data_d  = cpu_cmd_data;
          req_tag_d   = in_tag_c;
          if (!hit_c) begin
            state_d            = ST_FILL_REQ;
            cpu_cmd_ready_d    = 1'b0;
            data_cmd_valid_d   = 1'b1;
            data_cmd_write_d   = 1'b0;
            data_cmd_address_d = {in_tag_c, {OFS_BITS{1'b0}}};
          end else if (cpu_cmd_write) begin
            merged_c           = merge_word(line_q, in_widx_c, cpu_cmd_be, cpu_cmd_data);
            line_d             = merged_c;
            state_d            = ST_WB_REQ;
            cpu_cmd_ready_d    = 1'b0;
            data_cmd_valid_d   = 1'b1;
            data_cmd_write_d   = 1'b1;
            data_cmd_address_d = {in_tag_c, {OFS_BITS{1'b0}}};
            data_cmd_data_d    = merged_c;
          end else begin
            cpu_rsp_valid_d = 1'b1;
            cpu_rsp_data_d  = pick_word(line_q, in_widx_c);
          end
        end
      end

      ST_FILL_REQ: begin
        if (ack_fire_c) begin
          data_cmd_valid_d = 1'b0;
          state_d          = ST_FILL_WAIT;
        end
      end

      // Only a fresh rising edge of data_rsp_ready belongs to our fill
      ST_FILL_WAIT: begin
        if (rsp_edge_c) begin
          tag_d        = req_tag_q;
          line_valid_d = 1'b1;
          if (req_write_q) begin
            merged_c         = merge_word(data_rsp_data_i, req_widx_q, req_be_q, req_data_q);
            line_d           = merged_c;
            data_cmd_valid_d = 1'b1;
            data_cmd_write_d = 1'b1;
            data_cmd_data_d  = merged_c;
            state_d          = ST_WB_REQ;
          end else begin
            line_d          = data_rsp_data_i;
            cpu_rsp_valid_d = 1'b1;
            cpu_rsp_data_d  = pick_word(data_rsp_data_i, req_widx_q);
            cpu_cmd_ready_d = 1'b1;
            state_d         = ST_IDLE;
          end
        end
      end

      ST_WB_REQ: begin
        if (ack_fire_c) begin
          data_cmd_valid_d = 1'b0;
          cpu_rsp_valid_d  = 1'b1;
          cpu_rsp_data_d   = 32'h0;
          cpu_cmd_ready_d  = 1'b1;
          state_d          = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, buffer and registered outputs
  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      line_valid_q     <= 1'b0;
      tag_q            <= '0;
      line_q           <= '0;
      req_write_q      <= 1'b0;
      req_widx_q       <= '0;
      req_be_q         <= '0;
      req_data_q       <= '0;
      req_tag_q        <= '0;
      rsp_prev_q       <= 1'b1;
      cpu_cmd_ready    <= 1'b0;
      cpu_rsp_valid    <= 1'b0;
      cpu_rsp_data     <= '0;
      data_cmd_valid   <= 1'b0;
      data_cmd_address <= '0;
      data_cmd_write   <= 1'b0;
      data_cmd_data_o  <= '0;
    end else begin
      state_q          <= state_d;
      line_valid_q     <= line_valid_d;
      tag_q            <= tag_d;
      line_q           <= line_d;
      req_write_q      <= req_write_d;
      req_widx_q       <= req_widx_d;
      req_be_q         <= req_be_d;
      req_data_q       <= req_data_d;
      req_tag_q        <= req_tag_d;
      rsp_prev_q       <= data_rsp_ready;
      cpu_cmd_ready    <= cpu_cmd_ready_d;
      cpu_rsp_valid    <= cpu_rsp_valid_d;
      cpu_rsp_data     <= cpu_rsp_data_d;
      data_cmd_valid   <= data_cmd_valid_d;
      data_cmd_address <= data_cmd_address_d;
      data_cmd_write   <= data_cmd_write_d;
      data_cmd_data_o  <= data_cmd_data_d;
    end
  end

endmodule

// File: tb/tb_sddr_cpu_line_bridge.sv
// Scoreboard bench for sddr_cpu_line_bridge: reference cache/memory model,
// behavioural DDR controller, decoupled response and command monitors.
module tb_sddr_cpu_line_bridge;

  logic         clk;
  logic         reset_i;
  logic         cpu_cmd_valid;
  logic         cpu_cmd_ready;
  logic [31:0]  cpu_cmd_address;
  logic         cpu_cmd_write;
  logic [3:0]   cpu_cmd_be;
  logic [31:0]  cpu_cmd_data;
  logic         cpu_rsp_valid;
  logic [31:0]  cpu_rsp_data;
  logic         data_cmd_valid;
  logic [26:0]  data_cmd_address;
  logic         data_cmd_write;
  logic [127:0] data_cmd_data_o;
  logic         data_cmd_ack;
  logic         data_rsp_ready;
  logic [127:0] data_rsp_data_i;

  sddr_cpu_line_bridge dut (
    .cpu_clock_i      (clk),
    .reset_i          (reset_i),
    .cpu_cmd_valid    (cpu_cmd_valid),
    .cpu_cmd_ready    (cpu_cmd_ready),
    .cpu_cmd_address  (cpu_cmd_address),
    .cpu_cmd_write    (cpu_cmd_write),
    .cpu_cmd_be       (cpu_cmd_be),
    .cpu_cmd_data     (cpu_cmd_data),
    .cpu_rsp_valid    (cpu_rsp_valid),
    .cpu_rsp_data     (cpu_rsp_data),
    .data_cmd_valid   (data_cmd_valid),
    .data_cmd_address (data_cmd_address),
    .data_cmd_write   (data_cmd_write),
    .data_cmd_data_o  (data_cmd_data_o),
    .data_cmd_ack     (data_cmd_ack),
    .data_rsp_ready   (data_rsp_ready),
    .data_rsp_data_i  (data_rsp_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [26:0]  addr;
    logic [127:0] data;
  } cmd_t;

  int n_checks = 0;
  int n_pass   = 0;

  cmd_t         exp_cmd[$];
  logic [31:0]  exp_rsp[$];
  logic [127:0] ref_mem[int];
  logic [127:0] ctl_mem[int];
  bit           ref_valid = 1'b0;
  int           ref_tag   = 0;
  int           ack_delay_override = -1;
  bit           long_rsp = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [127:0] init_line(input int la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++)
      l[32*i +: 32] = (32'(la) * 32'h9E3779B1 + 32'(i) * 32'h01000193) ^ 32'h5A5A0000;
    return l;
  endfunction

  function automatic logic [127:0] ref_line(input int la);
    if (!ref_mem.exists(la)) ref_mem[la] = init_line(la);
    return ref_mem[la];
  endfunction

  function automatic logic [127:0] ctl_line(input int la);
    if (!ctl_mem.exists(la)) ctl_mem[la] = init_line(la);
    return ctl_mem[la];
  endfunction

  // Reference: single-line write-through cache in front of a line memory
  task automatic model_op(input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
    int           la;
    int           w;
    logic [127:0] l;
    bit           hit;
    la  = int'(addr[26:4]);
    w   = int'(addr[3:2]);
    hit = ref_valid && (ref_tag == la);
    l   = ref_line(la);
    if (!hit) exp_cmd.push_back('{wr: 1'b0, addr: 27'(la * 16), data: '0});
    ref_valid = 1'b1;
    ref_tag   = la;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) l[(4*w + b)*8 +: 8] = data[8*b +: 8];
      ref_mem[la] = l;
      exp_cmd.push_back('{wr: 1'b1, addr: 27'(la * 16), data: l});
      exp_rsp.push_back(32'h0);
    end else begin
      exp_rsp.push_back(l[32*w +: 32]);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance
  task automatic issue(input bit wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    int t;
    model_op(wr, addr, be, data);
    cpu_cmd_valid   = 1'b1;
    cpu_cmd_write   = wr;
    cpu_cmd_address = addr;
    cpu_cmd_be      = be;
    cpu_cmd_data    = data;
    t = 0;
    while (!cpu_cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("accept_timeout");
    @(negedge clk);
    cpu_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_rsp_queue", 128'(exp_rsp.size()), 128'(0));
    check("drain_cmd_queue", 128'(exp_cmd.size()), 128'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 128'(cpu_cmd_ready), 128'(0));
    check("rst_rsp_valid", 128'(cpu_rsp_valid), 128'(0));
    check("rst_rsp_data", 128'(cpu_rsp_data), 128'(0));
    check("rst_dcmd_valid", 128'(data_cmd_valid), 128'(0));
    check("rst_dcmd_write", 128'(data_cmd_write), 128'(0));
    check("rst_dcmd_addr", 128'(data_cmd_address), 128'(0));
    check("rst_dcmd_data", data_cmd_data_o, 128'(0));
  endtask

  // Behavioural DDR controller: checks each command, acks, answers reads with an edge
  initial begin
    cmd_t         c;
    cmd_t         e;
    int           d;
    int           la;
    logic [127:0] l;
    data_cmd_ack    = 1'b0;
    data_rsp_ready  = 1'b1;
    data_rsp_data_i = '0;
    forever begin
      @(negedge clk);
      if (data_cmd_valid && !reset_i) begin
        c  = '{wr: data_cmd_write, addr: data_cmd_address, data: data_cmd_data_o};
        la = int'(c.addr[26:4]);
        if (exp_cmd.size() == 0) begin
          fail_now("unexpected_controller_cmd");
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_write", 128'(c.wr), 128'(e.wr));
          check("cmd_addr", 128'(c.addr), 128'(e.addr));
          if (e.wr) check("cmd_data", c.data, e.data);
        end
        d = (ack_delay_override >= 0) ? ack_delay_override : int'($urandom_range(0, 4));
        repeat (d) @(negedge clk);
        data_cmd_ack = 1'b1;
        @(negedge clk);
        data_cmd_ack = 1'b0;
        if (c.wr) begin
          ctl_mem[la] = c.data;
        end else begin
          l = ctl_line(la);
          d = long_rsp ? 12 : int'($urandom_range(1, 5));
          data_rsp_ready = 1'b0;
          repeat (d) @(negedge clk);
          data_rsp_data_i = l;
          data_rsp_ready  = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          data_rsp_ready  = 1'b0;
          data_rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // Monitors: CPU responses against the scoreboard, command stability while stalled
  logic         prev_valid = 1'b0;
  logic [26:0]  prev_addr;
  logic         prev_write;
  logic [127:0] prev_data;

  always @(posedge clk) begin
    #1;
    if (cpu_rsp_valid) begin
      if (exp_rsp.size() == 0) fail_now("unexpected_cpu_rsp");
      else check("cpu_rsp_data", 128'(cpu_rsp_data), 128'(exp_rsp.pop_front()));
    end
    if (prev_valid && !reset_i) begin
      if (data_cmd_ack) begin
        check("cmd_drop_after_ack", 128'(data_cmd_valid), 128'(0));
      end else begin
        check("cmd_hold_valid", 128'(data_cmd_valid), 128'(1));
        check("cmd_hold_addr", 128'(data_cmd_address), 128'(prev_addr));
        check("cmd_hold_write", 128'(data_cmd_write), 128'(prev_write));
        check("cmd_hold_data", data_cmd_data_o, prev_data);
        check("cmd_stall_ready", 128'(cpu_cmd_ready), 128'(0));
      end
    end
    prev_valid = data_cmd_valid;
    prev_addr  = data_cmd_address;
    prev_write = data_cmd_write;
    prev_data  = data_cmd_data_o;
  end

  initial begin
    logic [127:0] l;
    logic [31:0]  a;
    int           t;
    reset_i         = 1'b1;
    cpu_cmd_valid   = 1'b0;
    cpu_cmd_address = '0;
    cpu_cmd_write   = 1'b0;
    cpu_cmd_be      = '0;
    cpu_cmd_data    = '0;

    l = init_line(32'h10);
    l[31:0]  = 32'hFFFFFFFF;
    l[63:32] = 32'hDEADBEEF;
    ref_mem[32'h10] = l;
    ctl_mem[32'h10] = l;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 128'(cpu_cmd_ready), 128'(1));

    // Read miss with a stalled ack, while data_rsp_ready is still high from reset
    ack_delay_override = 10;
    issue(1'b0, 32'h0000_0104, 4'h0, 32'h0);
    wait_idle();
    ack_delay_override = -1;
    issue(1'b0, 32'h0000_0108, 4'h0, 32'h0);
    wait_idle();
    issue(1'b1, 32'h0000_0100, 4'b0011, 32'h1234ABCD);
    wait_idle();
    issue(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    issue(1'b0, 32'h0000_0104, 4'h0, 32'h0);
    wait_idle();

    // Write miss with read-modify-write, then a hit on the new tag and a be=0 write
    issue(1'b1, 32'h0000_0200, 4'b0110, 32'hA5C3_7E19);
    wait_idle();
    issue(1'b0, 32'h0000_0200, 4'h0, 32'h0);
    issue(1'b1, 32'h0000_0204, 4'b0000, 32'h5555_5555);
    wait_idle();
    issue(1'b0, 32'h0000_0204, 4'h0, 32'h0);
    wait_idle();

    // Random mix over a handful of lines, with junk in the ignored address bits
    for (int i = 0; i < 300; i++) begin
      a = {5'($urandom), 27'(($urandom_range(0, 5) + 32'h40) * 16 + $urandom_range(0, 15))};
      issue(1'(($urandom % 2)), a, 4'($urandom), $urandom);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle();

    // Reset while waiting for a fill; the late edge must be ignored
    long_rsp = 1'b1;
    issue(1'b0, 32'h0000_7770, 4'h0, 32'h0);
    t = 0;
    while (data_cmd_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("fill_ack_timeout");
    @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_i = 1'b0;
    void'(exp_rsp.pop_back());
    ref_valid = 1'b0;
    long_rsp  = 1'b0;
    repeat (20) @(negedge clk);
    issue(1'b0, 32'h0000_7770, 4'h0, 32'h0);
    wait_idle();
    issue(1'b0, 32'h0000_7774, 4'h0, 32'h0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
